// File: rtl/uart_bus_arbiter.sv
// rtl/uart_bus_arbiter.sv - two-port round-robin arbiter and timed bus-cycle sequencer for the UART register bus
module uart_bus_arbiter #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       we0_i,
    input  logic       we1_i,
    input  logic [3:0] addr0_i,
    input  logic [3:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic [7:0] rdata0_o,
    output logic [7:0] rdata1_o,
    output logic [1:0] grant_o,
    output logic [3:0] AddrBus_o,
    output logic       n_ChipSelect_o,
    output logic       n_rd_o,
    output logic       n_we_o,
    output logic [7:0] DataBus_o,
    input  logic [7:0] DataBus_i
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_ACK    = 3'd4;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] sample_q, sample_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic [1:0] grant_q, grant_d;
    logic       n_cs_q, n_cs_d;
    logic       n_rd_q, n_rd_d;
    logic       n_we_q, n_we_d;
    logic [3:0] abus_q, abus_d;
    logic [7:0] dbus_q, dbus_d;
    logic       win;
    logic       bus_active;
    logic       strobe_active;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sample_d = sample_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    // Under contention the port that was not served last wins.
                    win     = (req0_i && req1_i) ? ~last_q : req1_i;
                    owner_d = win;
                    we_d    = win ? we1_i    : we0_i;
                    addr_d  = win ? addr1_i  : addr0_i;
                    wdata_d = win ? wdata1_i : wdata0_i;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    if (!we_q) begin
                        sample_d = DataBus_i;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_ACK;
                // Read data lands on the port register together with its ack.
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1_d = sample_q;
                    end else begin
                        rdata0_d = sample_q;
                    end
                end
            end
            ST_ACK: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus pins are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        bus_active    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        strobe_active = (state_d == ST_STROBE);
        grant_d       = (state_d == ST_IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
        ack0_d        = (state_d == ST_ACK) && !owner_d;
        ack1_d        = (state_d == ST_ACK) && owner_d;
        n_cs_d        = !bus_active;
        abus_d        = bus_active ? addr_d : 4'h0;
        n_rd_d        = !(strobe_active && !we_d);
        n_we_d        = !(strobe_active && we_d);
        dbus_d        = ((strobe_active || (state_d == ST_HOLD)) && we_d) ? wdata_d : 8'h00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 4'h0;
            wdata_q  <= 8'h00;
            sample_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sample_q <= sample_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            grant_q  <= 2'b00;
            n_cs_q   <= 1'b1;
            n_rd_q   <= 1'b1;
            n_we_q   <= 1'b1;
            abus_q   <= 4'h0;
            dbus_q   <= 8'h00;
        end else begin
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            grant_q  <= grant_d;
            n_cs_q   <= n_cs_d;
            n_rd_q   <= n_rd_d;
            n_we_q   <= n_we_d;
            abus_q   <= abus_d;
            dbus_q   <= dbus_d;
        end
    end

    assign ack0_o         = ack0_q;
    assign ack1_o         = ack1_q;
    assign rdata0_o       = rdata0_q;
    assign rdata1_o       = rdata1_q;
    assign grant_o        = grant_q;
    assign AddrBus_o      = abus_q;
    assign n_ChipSelect_o = n_cs_q;
    assign n_rd_o         = n_rd_q;
    assign n_we_o         = n_we_q;
    assign DataBus_o      = dbus_q;

endmodule
